// File: rtl/conv1d_seq_module.sv
// conv1d_seq_module: time-multiplexed 1-D convolution, one MAC per cycle.
// Latches a multi-channel frame window at start, walks every (oc, of, ic, k)
// tap, then requantises each accumulator with round-half-up, saturation and
// optional ReLU.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_start; weight/bias writes accepted here only
// MAC     | one tap per cycle, k innermost then ic
// WRITE   | requantise acc into buffer[oc][of], preload next bias
// DONE    | copy buffer to o_result, pulse o_done_tick
module conv1d_seq_module #(
    parameter int DATA_WIDTH       = 16,
    parameter int FRACTIONAL_BITS  = 8,
    parameter int NUM_IN_CHANNELS  = 4,
    parameter int NUM_OUT_CHANNELS = 2,
    parameter int KERNEL_SIZE      = 3,
    parameter int PADDING          = 1,
    parameter int STRIDE           = 1,
    parameter int DILATION         = 1,
    parameter int NUM_IN_FRAMES    = 2,
    parameter int ACC_WIDTH        = 40,
    localparam int NOF = (NUM_IN_FRAMES + 2*PADDING - DILATION*(KERNEL_SIZE-1) - 1)/STRIDE + 1,
    localparam int NW  = NUM_OUT_CHANNELS*NUM_IN_CHANNELS*KERNEL_SIZE,
    localparam int WA  = (NW > 1) ? $clog2(NW) : 1,
    localparam int BA  = (NUM_OUT_CHANNELS > 1) ? $clog2(NUM_OUT_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wt_we,
    input  logic [WA-1:0]         i_wt_addr,
    input  logic [DATA_WIDTH-1:0] i_wt_data,
    input  logic                  i_bias_we,
    input  logic [BA-1:0]         i_bias_addr,
    input  logic [DATA_WIDTH-1:0] i_bias_data,
    input  logic                  i_relu_en,
    input  logic                  i_start,
    input  logic signed [NUM_IN_CHANNELS-1:0][NUM_IN_FRAMES-1:0][DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  o_done_tick,
    output logic signed [NUM_OUT_CHANNELS-1:0][NOF-1:0][DATA_WIDTH-1:0] o_result,
    output logic                  o_sat_flag
);
    localparam int KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int ICW  = (NUM_IN_CHANNELS > 1) ? $clog2(NUM_IN_CHANNELS) : 1;
    localparam int OFW  = (NOF > 1) ? $clog2(NOF) : 1;
    localparam int OCW  = (NUM_OUT_CHANNELS > 1) ? $clog2(NUM_OUT_CHANNELS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(1) <<< (FRACTIONAL_BITS-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (DATA_WIDTH-1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(1) <<< (DATA_WIDTH-1));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic signed [DATA_WIDTH-1:0] r_wt   [NW];
    logic signed [DATA_WIDTH-1:0] r_bias [NUM_OUT_CHANNELS];
    logic signed [DATA_WIDTH-1:0] r_data [NUM_IN_CHANNELS][NUM_IN_FRAMES];
    logic signed [DATA_WIDTH-1:0] r_buf  [NUM_OUT_CHANNELS][NOF];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [KW-1:0]           r_k;
    logic [ICW-1:0]          r_ic;
    logic [OFW-1:0]          r_of;
    logic [OCW-1:0]          r_oc;
    logic                    r_relu, r_sat, r_done;
    logic signed [NUM_OUT_CHANNELS-1:0][NOF-1:0][DATA_WIDTH-1:0] r_result;

    int                             w_tap;
    logic signed [DATA_WIDTH-1:0]   w_x, w_w, w_q, w_bias0, w_next_bias;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_shr;
    logic                           w_clip, w_last_tap, w_last_of, w_last_oc;

    function automatic logic signed [ACC_WIDTH-1:0] f_bias_acc(input logic signed [DATA_WIDTH-1:0] b);
        return {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b} <<< FRACTIONAL_BITS;
    endfunction

    assign o_busy      = (r_state != S_IDLE);
    assign o_done_tick = r_done;
    assign o_result    = r_result;
    assign o_sat_flag  = r_sat;

    assign w_last_tap = (r_k == KW'(KERNEL_SIZE-1)) && (r_ic == ICW'(NUM_IN_CHANNELS-1));
    assign w_last_of  = (r_of == OFW'(NOF-1));
    assign w_last_oc  = (r_oc == OCW'(NUM_OUT_CHANNELS-1));
    // a bias write coinciding with an accepted start must reach the first accumulator
    assign w_bias0    = (i_bias_we && int'(i_bias_addr) == 0) ? i_bias_data : r_bias[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_MAC;
            S_MAC:   if (w_last_tap) w_next = S_WRITE;
            S_WRITE: w_next = (w_last_of && w_last_oc) ? S_DONE : S_MAC;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Tap fetch, product, requantisation and next-bias selection
    always_comb begin
        w_tap = int'(r_of)*STRIDE + int'(r_k)*DILATION - PADDING;
        w_x   = '0;
        if (w_tap >= 0 && w_tap < NUM_IN_FRAMES) w_x = r_data[int'(r_ic)][w_tap];
        w_w    = r_wt[(int'(r_oc)*NUM_IN_CHANNELS + int'(r_ic))*KERNEL_SIZE + int'(r_k)];
        w_prod = w_x * w_w;
        w_shr  = (r_acc + RND) >>> FRACTIONAL_BITS;
        w_clip = 1'b0;
        if (w_shr > SAT_MAX) begin
            w_q    = SAT_MAX[DATA_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_shr < SAT_MIN) begin
            w_q    = SAT_MIN[DATA_WIDTH-1:0];
            w_clip = 1'b1;
        end else begin
            w_q = w_shr[DATA_WIDTH-1:0];
        end
        if (r_relu && w_q[DATA_WIDTH-1]) w_q = '0;
        w_next_bias = r_bias[0];
        if (!(w_last_of && w_last_oc))
            w_next_bias = w_last_of ? r_bias[int'(r_oc) + 1] : r_bias[int'(r_oc)];
    end

    // Register file writes, operand latching, accumulation and result buffering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) r_wt[i] <= '0;
            for (int o = 0; o < NUM_OUT_CHANNELS; o++) begin
                r_bias[o] <= '0;
                for (int f = 0; f < NOF; f++) r_buf[o][f] <= '0;
            end
            for (int c = 0; c < NUM_IN_CHANNELS; c++)
                for (int f = 0; f < NUM_IN_FRAMES; f++) r_data[c][f] <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_ic     <= '0;
            r_of     <= '0;
            r_oc     <= '0;
            r_relu   <= 1'b0;
            r_sat    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (i_wt_we && r_state == S_IDLE && int'(i_wt_addr) < NW)
                r_wt[i_wt_addr] <= i_wt_data;
            if (i_bias_we && r_state == S_IDLE && int'(i_bias_addr) < NUM_OUT_CHANNELS)
                r_bias[i_bias_addr] <= i_bias_data;
            case (r_state)
                S_IDLE: if (i_start) begin
                    for (int c = 0; c < NUM_IN_CHANNELS; c++)
                        for (int f = 0; f < NUM_IN_FRAMES; f++) r_data[c][f] <= i_data[c][f];
                    r_relu <= i_relu_en;
                    r_sat  <= 1'b0;
                    r_k    <= '0;
                    r_ic   <= '0;
                    r_of   <= '0;
                    r_oc   <= '0;
                    r_acc  <= f_bias_acc(w_bias0);
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                    if (r_k == KW'(KERNEL_SIZE-1)) begin
                        r_k  <= '0;
                        r_ic <= (r_ic == ICW'(NUM_IN_CHANNELS-1)) ? '0 : r_ic + 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_buf[int'(r_oc)][int'(r_of)] <= w_q;
                    if (w_clip) r_sat <= 1'b1;
                    r_acc <= f_bias_acc(w_next_bias);
                    if (w_last_of) begin
                        r_of <= '0;
                        r_oc <= w_last_oc ? '0 : r_oc + 1'b1;
                    end else begin
                        r_of <= r_of + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int o = 0; o < NUM_OUT_CHANNELS; o++)
                        for (int f = 0; f < NOF; f++) r_result[o][f] <= r_buf[o][f];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_seq_module.sv
// Bench for conv1d_seq_module: directed test-plan cases plus random runs
// against an arithmetic reference model, and a second parameter set.
module tb_conv1d_seq_module;
    localparam int NIC = 4, NOC = 2, NIF = 2, NOF = 2, K = 3, NW = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_wt_we, i_bias_we, i_relu_en, i_start;
    logic [4:0]  i_wt_addr;
    logic [0:0]  i_bias_addr;
    logic [15:0] i_wt_data, i_bias_data;
    logic signed [NIC-1:0][NIF-1:0][15:0] d_data;
    logic        o_busy, o_done_tick, o_sat_flag;
    logic signed [NOC-1:0][NOF-1:0][15:0] o_result;

    conv1d_seq_module dut (
        .clk(clk), .rst_n(rst_n),
        .i_wt_we(i_wt_we), .i_wt_addr(i_wt_addr), .i_wt_data(i_wt_data),
        .i_bias_we(i_bias_we), .i_bias_addr(i_bias_addr), .i_bias_data(i_bias_data),
        .i_relu_en(i_relu_en), .i_start(i_start), .i_data(d_data),
        .o_busy(o_busy), .o_done_tick(o_done_tick), .o_result(o_result), .o_sat_flag(o_sat_flag)
    );

    // second configuration: NIC=NOC=1, NIF=5, K=3, stride 2, dilation 2, padding 2
    logic        b_wt_we, b_bias_we, b_start, b_busy, b_done, b_sat;
    logic [1:0]  b_wt_addr;
    logic [0:0]  b_bias_addr;
    logic [15:0] b_wt_data, b_bias_data;
    logic signed [0:0][4:0][15:0] b_data;
    logic signed [0:0][2:0][15:0] b_result;

    conv1d_seq_module #(
        .NUM_IN_CHANNELS(1), .NUM_OUT_CHANNELS(1), .KERNEL_SIZE(3), .PADDING(2),
        .STRIDE(2), .DILATION(2), .NUM_IN_FRAMES(5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_wt_we(b_wt_we), .i_wt_addr(b_wt_addr), .i_wt_data(b_wt_data),
        .i_bias_we(b_bias_we), .i_bias_addr(b_bias_addr), .i_bias_data(b_bias_data),
        .i_relu_en(1'b0), .i_start(b_start), .i_data(b_data),
        .o_busy(b_busy), .o_done_tick(b_done), .o_result(b_result), .o_sat_flag(b_sat)
    );

    int     m_w [NW];
    int     m_b [NOC];
    int     x   [NIC][NIF];
    longint e_res [NOC][NOF];
    bit     e_sat;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint res(input int oc, input int of);
        return longint'($signed(o_result[oc][of]));
    endfunction

    // Reference: bias*2^8 plus sum of in-range tap products, floor((acc+128)/256), clip, ReLU
    task automatic model(input bit relu);
        e_sat = 1'b0;
        for (int oc = 0; oc < NOC; oc++)
            for (int of = 0; of < NOF; of++) begin
                longint acc, q;
                acc = longint'(m_b[oc]) * 256;
                for (int ic = 0; ic < NIC; ic++)
                    for (int k = 0; k < K; k++) begin
                        int t;
                        t = of + k - 1;
                        if (t >= 0 && t < NIF)
                            acc += longint'(m_w[(oc*NIC + ic)*K + k]) * longint'(x[ic][t]);
                    end
                q = acc + 128;
                q = (q >= 0) ? q / 256 : -((-q + 255) / 256);
                if (q > 32767)  begin q = 32767;  e_sat = 1'b1; end
                if (q < -32768) begin q = -32768; e_sat = 1'b1; end
                if (relu && q < 0) q = 0;
                e_res[oc][of] = q;
            end
    endtask

    task automatic wr_wt(input int addr, input int val);
        @(negedge clk);
        i_wt_we = 1'b1; i_wt_addr = 5'(addr); i_wt_data = 16'(val);
        @(negedge clk);
        i_wt_we = 1'b0;
        if (addr < NW) m_w[addr] = val;
    endtask

    task automatic wr_bias(input int addr, input int val);
        @(negedge clk);
        i_bias_we = 1'b1; i_bias_addr = 1'(addr); i_bias_data = 16'(val);
        @(negedge clk);
        i_bias_we = 1'b0;
        m_b[addr] = val;
    endtask

    task automatic clear_x();
        for (int c = 0; c < NIC; c++) for (int f = 0; f < NIF; f++) x[c][f] = 0;
    endtask

    // One run; optional ignored start/write glitch, mid-run reset, or bias write on the start edge
    task automatic run(input bit relu, input int glitch_at, input int rst_at, input bit sbw, input int sbv);
        int n;
        @(negedge clk);
        for (int c = 0; c < NIC; c++) for (int f = 0; f < NIF; f++) d_data[c][f] = 16'(x[c][f]);
        i_relu_en = relu;
        i_start   = 1'b1;
        if (sbw) begin
            i_bias_we = 1'b1; i_bias_addr = 1'b0; i_bias_data = 16'(sbv);
            m_b[0] = sbv;
        end
        model(relu);
        @(negedge clk);
        i_start = 1'b0; i_bias_we = 1'b0; i_relu_en = ~relu;
        for (int c = 0; c < NIC; c++) for (int f = 0; f < NIF; f++) d_data[c][f] = 16'($urandom);
        n = 0;
        while (o_done_tick !== 1'b1 && n < 100) begin
            @(posedge clk); n++; #1;
            if (n == 1) check("busy_during_run", longint'(o_busy), 1);
            if (n == glitch_at - 1) begin
                i_start = 1'b1; i_wt_we = 1'b1; i_wt_addr = 5'd1; i_wt_data = 16'h7fff;
            end
            if (n == glitch_at) begin i_start = 1'b0; i_wt_we = 1'b0; end
            if (n == rst_at) begin
                int seen;
                rst_n = 1'b0;
                #1;
                check("rst_busy", longint'(o_busy), 0);
                check("rst_result", longint'(o_result), 0);
                check("rst_sat", longint'(o_sat_flag), 0);
                seen = 0;
                repeat (60) begin @(posedge clk); #1; if (o_done_tick) seen = 1; end
                check("rst_no_done", seen, 0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < NW; i++) m_w[i] = 0;
                for (int i = 0; i < NOC; i++) m_b[i] = 0;
                return;
            end
        end
        check("done_latency", n, 53);
        check("busy_at_done", longint'(o_busy), 0);
        for (int oc = 0; oc < NOC; oc++)
            for (int of = 0; of < NOF; of++)
                check($sformatf("result_oc%0d_of%0d", oc, of), res(oc, of), e_res[oc][of]);
        check("sat_flag", longint'(o_sat_flag), longint'(e_sat));
        @(posedge clk); #1;
        check("done_one_cycle", longint'(o_done_tick), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        i_wt_we = 0; i_bias_we = 0; i_start = 0; i_relu_en = 0;
        i_wt_addr = '0; i_bias_addr = '0; i_wt_data = '0; i_bias_data = '0; d_data = '0;
        b_wt_we = 0; b_bias_we = 0; b_start = 0; b_wt_addr = '0; b_bias_addr = '0;
        b_wt_data = '0; b_bias_data = '0; b_data = '0;
        for (int i = 0; i < NW; i++) m_w[i] = 0;
        for (int i = 0; i < NOC; i++) m_b[i] = 0;
        clear_x();
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(o_busy), 0);
        check("reset_done", longint'(o_done_tick), 0);
        check("reset_result", longint'(o_result), 0);
        check("reset_sat", longint'(o_sat_flag), 0);
        rst_n = 1'b1;

        // identity tap on IC0
        wr_wt(1, 256); x[0][0] = 20; x[0][1] = 30;
        run(0, 0, 0, 0, 0);
        check("t1_oc0_of0", res(0, 0), 20); check("t1_oc0_of1", res(0, 1), 30);
        check("t1_oc1_of0", res(1, 0), 0);  check("t1_oc1_of1", res(1, 1), 0);

        // padding taps
        wr_wt(1, 0); wr_wt(21, 256); wr_wt(23, 512);
        clear_x(); x[3][0] = 40; x[3][1] = 50;
        run(0, 0, 0, 0, 0);
        check("t2_oc1_of0", res(1, 0), 100); check("t2_oc1_of1", res(1, 1), 40);
        check("t2_oc0_of0", res(0, 0), 0);   check("t2_oc0_of1", res(0, 1), 0);

        // rounding with negative bias
        wr_wt(21, 0); wr_wt(23, 0); wr_wt(1, 128); wr_bias(0, -1);
        clear_x(); x[0][0] = 3; x[0][1] = -3;
        run(0, 0, 0, 0, 0);
        check("t3_of0", res(0, 0), 1); check("t3_of1", res(0, 1), -2);

        // saturation and ReLU, then a clean run clears the flag
        wr_bias(0, 0); wr_wt(1, 32767);
        x[0][0] = 32767; x[0][1] = -32768;
        run(0, 0, 0, 0, 0);
        check("t4_of0", res(0, 0), 32767); check("t4_of1", res(0, 1), -32768);
        check("t4_sat", longint'(o_sat_flag), 1);
        run(1, 0, 0, 0, 0);
        check("t4r_of0", res(0, 0), 32767); check("t4r_of1", res(0, 1), 0);
        x[0][0] = 1; x[0][1] = 2;
        run(0, 0, 0, 0, 0);
        check("t4c_sat", longint'(o_sat_flag), 0);

        // start and weight write while busy are ignored
        run(0, 10, 0, 0, 0);
        // reset mid-run, then reload and rerun
        run(0, 0, 20, 0, 0);
        wr_wt(1, 256); x[0][0] = 20; x[0][1] = 30;
        run(0, 0, 0, 0, 0);
        // bias written on the start edge is used; out-of-range weight write dropped
        wr_wt(27, 99);
        run(0, 0, 0, 1, 1000);
        check("t7_oc0_of0", res(0, 0), 1020);

        // random back-to-back runs
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NW; i++)
                wr_wt(i, (it < 3) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 65535)) - 32768);
            for (int i = 0; i < NOC; i++) wr_bias(i, int'($urandom_range(0, 2047)) - 1024);
            for (int c = 0; c < NIC; c++)
                for (int f = 0; f < NIF; f++) x[c][f] = int'($urandom_range(0, 65535)) - 32768;
            run(1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end

        // second configuration
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); b_wt_we = 1'b1; b_wt_addr = 2'(i); b_wt_data = 16'd256;
        end
        @(negedge clk);
        b_wt_we = 1'b0;
        for (int f = 0; f < 5; f++) b_data[0][f] = 16'(f + 1);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 50) begin @(posedge clk); n++; #1; end
        check("b_latency", n, 13);
        check("b_of0", longint'($signed(b_result[0][0])), 4);
        check("b_of1", longint'($signed(b_result[0][1])), 9);
        check("b_of2", longint'($signed(b_result[0][2])), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv1d_seq_module.md
# conv1d_seq_module

Time-multiplexed, fully parametrised successor to the parallel Conv1 block in the decoder datapath. Computes a 1-D convolution over a latched multi-channel frame window with runtime-loadable weights and per-output-channel bias. Adds stride, dilation, round-half-up requantisation, saturation with a sticky flag, and optional ReLU. Uses one MAC per cycle, trading latency for area.

## Interface
- DATA_WIDTH, 16: sample/weight/bias width, signed Q(DATA_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS
- FRACTIONAL_BITS, 8: fractional bits of every operand and result
- NUM_IN_CHANNELS, 4: input channels (NIC)
- NUM_OUT_CHANNELS, 2: output channels (NOC)
- KERNEL_SIZE, 3: taps per kernel (K)
- PADDING, 1: zero frames on each side
- STRIDE, 1: output step in input frames
- DILATION, 1: tap spacing in input frames
- NUM_IN_FRAMES, 2: input frames (NIF)
- ACC_WIDTH, 40: accumulator width, ≥ 2*DATA_WIDTH + clog2(NIC*K) + 1
- Derived NOF = (NIF + 2*PADDING − DILATION*(K−1) − 1)/STRIDE + 1 (2 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_wt_we  in  1  weight write strobe
- i_wt_addr  in  clog2(NOC*NIC*K)  weight index = (oc*NIC + ic)*K + k
- i_wt_data  in  DATA_WIDTH  signed weight
- i_bias_we  in  1  bias write strobe
- i_bias_addr  in  clog2(NOC) (min 1)  output channel
- i_bias_data  in  DATA_WIDTH  signed bias
- i_relu_en  in  1  ReLU mode, latched at start
- i_start  in  1  start request
- i_data  in  [NIC][NIF] x DATA_WIDTH  signed input frames, latched at start
- o_busy  out  1  run in progress
- o_done_tick  out  1  one-cycle completion pulse
- o_result  out  [NOC][NOF] x DATA_WIDTH  signed results, registered
- o_sat_flag  out  1  at least one result saturated in the last run

## Operation
- FSM states:
  - IDLE: i_start=1 → MAC. Latch i_data and i_relu_en; clear o_sat_flag; zero counters; acc ← sign-extended bias[0] << FRACTIONAL_BITS.
  - MAC: one tap per cycle, loop order k innermost, then ic, of, oc. After tap NIC*K−1 → WRITE.
  - WRITE: requantise acc into result buffer[oc][of]; acc ← bias of next (oc,of). If last (oc,of) → DONE, else → MAC.
  - DONE: o_result ← buffer, o_done_tick=1 → IDLE.
- Tap input index = of*STRIDE + k*DILATION − PADDING. If outside [0, NIF−1], contribute zero. Cycle count is fixed regardless of padding.
- Product: full 2*DATA_WIDTH signed, sign-extended into ACC_WIDTH. No intermediate saturation.
- Requantise sequence:
  - add 1 << (FRACTIONAL_BITS−1), then arithmetic shift right FRACTIONAL_BITS (round half up);
  - saturate to [−2^(DW−1), 2^(DW−1)−1] and set o_sat_flag if clipped;
  - if ReLU is latched, force negative values to 0.
- Weights and biases are registers, reset to 0. Writes are accepted only in IDLE; writes while busy or to out-of-range addresses are dropped.
- A write in the same cycle as an accepted i_start commits, and the run uses the new value.
- i_start while o_busy=1 is ignored. i_data changes after the start edge have no effect.
- o_result holds its value until the next DONE.

## Timing
- Reset values: o_busy=0, o_done_tick=0, o_result all 0, o_sat_flag=0, weights/biases 0, FSM IDLE.
- Reset mid-run aborts immediately to the reset state. No done pulse.
- Start accepted at edge S: o_busy=1 from S, through DONE-entry.
- Done at edge S + NOC*NOF*(NIC*K+1) + 1 (S+53 at defaults). On that edge o_done_tick=1 for one cycle, o_busy=0, o_result valid.
- Next i_start is accepted at the edge following done (back-to-back allowed).

## Test plan
- Defaults, only w[0][0][1]=256, IC0={20,30}, others 0 → o_result OC0={20,30}, OC1={0,0}; o_done_tick at S+53; o_sat_flag=0.
- Padding taps: only w[1][3][0]=256, w[1][3][2]=512, IC3={40,50} → OC1={100,40}, OC0={0,0}.
- Rounding/bias: w[0][0][1]=128, bias[0]=−1, IC0={3,−3} → OC0={1,−2}.
- Saturation/ReLU: w[0][0][1]=32767, IC0={32767,−32768}:
  - relu=0 → OC0={32767,−32768}, o_sat_flag=1;
  - relu=1 → OC0={32767,0};
  - a following clean run clears the flag.
- Guards:
  - i_start and i_wt_we pulsed at S+10 are ignored; results unchanged, done still at S+53;
  - rst_n low at S+20 → o_busy=0, o_result 0, no done; a rerun after reloading weights gives the correct result.
- Second config NIC=NOC=1, NIF=5, K=3, STRIDE=2, DILATION=2, PADDING=2, weights 256, input {1,2,3,4,5} → {4,9,8}; done at S+13.
